mem_port_arbiter: RTL and testbench

- Sequences and shares the single-port byte-addressed main memory between two requesters: instruction fetch (IF) and load/store data (D).
- Arbitrates, then expands each granted request into 1/4/8/16 word beats per access_size.
- Drives the memory's address, data_in, access_size, rw and enable pins; returns read data per beat to the owning requester.
- Sits between the pipeline front/back ends and the memory block.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_rd_lat_pipe.sv | 35 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: size encodings, owner and state enums.
package mem_pkg;

    localparam logic [1:0] SZ_1W  = 2'b00;
    localparam logic [1:0] SZ_4W  = 2'b01;
    localparam logic [1:0] SZ_8W  = 2'b10;
    localparam logic [1:0] SZ_16W = 2'b11;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } arb_state_t;

    function automatic logic [4:0] beat_count(input logic [1:0] size);
        logic [4:0] n;
        case (size)
            SZ_1W:   n = 5'd1;
            SZ_4W:   n = 5'd4;
            SZ_8W:   n = 5'd8;
            SZ_16W:  n = 5'd16;
            default: n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus bundle for mem_port_arbiter; slave = arbiter view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        if_size;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        d_size;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wready;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [1:0]        mem_access_size;
    logic              mem_rw;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_busy;

    modport slave (
        input  if_req, if_addr, if_size,
        output if_gnt, if_rvalid, if_rdata, if_done,
        input  d_req, d_rw, d_addr, d_size, d_wdata,
        output d_wready, d_gnt, d_rvalid, d_rdata, d_done,
        output mem_addr, mem_data_in, mem_access_size, mem_rw, mem_enable,
        input  mem_data_out, mem_busy
    );

    modport master (
        output if_req, if_addr, if_size,
        input  if_gnt, if_rvalid, if_rdata, if_done,
        output d_req, d_rw, d_addr, d_size, d_wdata,
        input  d_wready, d_gnt, d_rvalid, d_rdata, d_done,
        input  mem_addr, mem_data_in, mem_access_size, mem_rw, mem_enable,
        output mem_data_out, mem_busy
    );
endinterface

// File: rtl/mem_rd_lat_pipe.sv
// Read-latency tracker: DEPTH-stage shift register of {valid, owner}, async active-low clear.
module mem_rd_lat_pipe
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   in_valid,
    input  owner_t in_owner,
    output logic   out_valid,
    output owner_t out_owner
);

    logic [DEPTH-1:0] vld;
    owner_t           own [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) own[i] <= OWN_IF;
        end else begin
            vld[0] <= in_valid;
            own[0] <= in_owner;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_owner = own[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / D) arbiter and burst sequencer for a single-port memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-IF priority.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state, state_next;
    owner_t            own_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        size_q;
    logic              rw_q;
    logic [4:0]        beat_q;
    logic [4:0]        ret_q;
    logic              wdone_q;

    logic              grant, pick_d, issue, last_beat, last_ret;
    logic              ret_valid;
    owner_t            ret_owner;
    logic [4:0]        n_beats;
    logic [DATA_W-1:0] rd_word;

    assign n_beats   = beat_count(size_q);
    assign rd_word   = bus.mem_data_out;
    assign issue     = (state == XFER) && !bus.mem_busy;
    assign last_beat = (beat_q == n_beats - 5'd1);
    assign last_ret  = ret_valid && (ret_q == n_beats - 5'd1);
    // Holding off grant during the write-done cycle keeps gnt and done apart on D.
    assign grant     = (state == IDLE) && !wdone_q && (bus.if_req || bus.d_req);

`ifdef MEM_ARB_RR_EN
    owner_t last_own_q;

    assign pick_d = bus.d_req && (!bus.if_req || (last_own_q == OWN_IF));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   last_own_q <= OWN_IF;
        else if (grant) last_own_q <= pick_d ? OWN_D : OWN_IF;
    end
`else
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = XFER;
            XFER:    if (issue && last_beat) state_next = rw_q ? IDLE : DRAIN;
            DRAIN:   if (last_ret) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            own_q   <= OWN_IF;
            base_q  <= '0;
            size_q  <= '0;
            rw_q    <= 1'b0;
            beat_q  <= '0;
            ret_q   <= '0;
            wdone_q <= 1'b0;
        end else begin
            wdone_q <= issue && last_beat && rw_q;
            if (grant) begin
                own_q  <= pick_d ? OWN_D : OWN_IF;
                base_q <= pick_d ? {bus.d_addr[ADDR_W-1:2], 2'b00}
                                 : {bus.if_addr[ADDR_W-1:2], 2'b00};
                size_q <= pick_d ? bus.d_size : bus.if_size;
                rw_q   <= pick_d && bus.d_rw;
                beat_q <= '0;
                ret_q  <= '0;
            end else begin
                if (issue)     beat_q <= beat_q + 5'd1;
                if (ret_valid) ret_q  <= ret_q + 5'd1;
            end
        end
    end

    mem_rd_lat_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (issue && !rw_q),
        .in_owner  (own_q),
        .out_valid (ret_valid),
        .out_owner (ret_owner)
    );

    always_comb begin
        bus.if_gnt          = 1'b0;
        bus.d_gnt           = 1'b0;
        bus.if_rvalid       = 1'b0;
        bus.if_rdata        = '0;
        bus.if_done         = 1'b0;
        bus.d_rvalid        = 1'b0;
        bus.d_rdata         = '0;
        bus.d_done          = wdone_q;
        bus.d_wready        = 1'b0;
        bus.mem_addr        = '0;
        bus.mem_data_in     = '0;
        bus.mem_access_size = '0;
        bus.mem_rw          = 1'b0;
        bus.mem_enable      = 1'b0;
        // Grant is combinational on req, so it is gated explicitly while in reset.
        if (reset_n && grant) begin
            if (pick_d) bus.d_gnt  = 1'b1;
            else        bus.if_gnt = 1'b1;
        end
        if (state == XFER) begin
            bus.mem_addr        = base_q + (ADDR_W'(beat_q) << 2);
            bus.mem_access_size = size_q;
            bus.mem_rw          = rw_q;
            bus.mem_enable      = !bus.mem_busy;
            bus.d_wready        = rw_q && !bus.mem_busy;
            if (rw_q) bus.mem_data_in = bus.d_wdata;
        end
        if (ret_valid) begin
            if (ret_owner == OWN_D) begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = rd_word;
                if (last_ret) bus.d_done = 1'b1;
            end else begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = rd_word;
                if (last_ret) bus.if_done = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboard-checked bench for mem_port_arbiter (RD_LAT=1); honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        last;
    } beat_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        last;
    } rd_t;

    beat_t       beat_q[$];
    rd_t         rd_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wexp = 0;
    int          wready_cnt = 0;
    int          d_done_cnt = 0;
    logic [31:0] wcnt = '0;
    logic [31:0] ra [RD_LAT];
    logic        wdone_pend = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester write data advances on each consumed beat; memory returns pat(addr) RD_LAT later.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.d_wready) wcnt <= wcnt + 1;
        if (bus.mem_enable && !bus.mem_rw) ra[0] <= bus.mem_addr;
        for (int i = 1; i < RD_LAT; i++) ra[i] <= ra[i-1];
    end
    assign bus.d_wdata      = 32'hD000_0000 + wcnt;
    assign bus.mem_data_out = pat(ra[RD_LAT-1]);

    always @(negedge clock) begin
        beat_t b;
        rd_t   r;
        logic  exp_if_done, exp_d_done;
        exp_if_done = 1'b0;
        exp_d_done  = wdone_pend;
        wdone_pend  = 1'b0;
        if (bus.d_wready) wready_cnt++;
        if (bus.d_done)   d_done_cnt++;
        if (bus.mem_enable) begin
            chk("beat_expected", beat_q.size() > 0, 1);
            if (beat_q.size() > 0) begin
                b = beat_q.pop_front();
                chk("mem_addr", bus.mem_addr, b.addr);
                chk("mem_rw", bus.mem_rw, b.rw);
                chk("d_wready", bus.d_wready, b.rw);
                if (b.rw) chk("mem_data_in", bus.mem_data_in, b.wdata);
                if (b.rw && b.last) wdone_pend = 1'b1;
            end
        end else begin
            chk("d_wready_idle", bus.d_wready, 0);
        end
        if (bus.if_rvalid || bus.d_rvalid) begin
            chk("rvalid_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                chk("if_rvalid", bus.if_rvalid, !r.port);
                chk("d_rvalid", bus.d_rvalid, r.port);
                chk("rdata", r.port ? bus.d_rdata : bus.if_rdata, pat(r.addr));
                if (r.last) begin
                    if (r.port) exp_d_done  = 1'b1;
                    else        exp_if_done = 1'b1;
                end
            end
        end
        chk("if_done", bus.if_done, exp_if_done);
        chk("d_done", bus.d_done, exp_d_done);
        if (!reset_n) wdone_pend = 1'b0;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic push_txn(input logic port, input logic rw, input logic [31:0] addr,
                            input logic [1:0] size);
        int          n;
        logic [31:0] a;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 4 : (size == 2'd2) ? 8 : 16;
        for (int i = 0; i < n; i++) begin
            a = {addr[31:2], 2'b00} + 32'(i * 4);
            if (rw) begin
                beat_q.push_back('{addr: a, rw: 1'b1, wdata: 32'hD000_0000 + 32'(wexp), last: (i == n - 1)});
                wexp++;
            end else begin
                beat_q.push_back('{addr: a, rw: 1'b0, wdata: '0, last: (i == n - 1)});
                rd_q.push_back('{port: port, addr: a, last: (i == n - 1)});
            end
        end
    endtask

    task automatic set_req(input logic port, input logic rw, input logic [31:0] addr,
                           input logic [1:0] size);
        if (port) begin
            bus.d_req = 1'b1; bus.d_rw = rw; bus.d_addr = addr; bus.d_size = size;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr; bus.if_size = size;
        end
    endtask

    task automatic run_txn(input logic port, input logic rw, input logic [31:0] addr,
                           input logic [1:0] size, output int gc, output int dc);
        int ng;
        bit got;
        ng = 0; got = 0; gc = -1; dc = -1;
        push_txn(port, rw, addr, size);
        set_req(port, rw, addr, size);
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            if (port ? bus.d_gnt : bus.if_gnt) begin ng++; gc = cyc; end
            if (port ? bus.d_done : bus.if_done) begin dc = cyc; got = 1; end
        end
        step;
        if (port) bus.d_req = 1'b0;
        else      bus.if_req = 1'b0;
        chk("txn_done_seen", got, 1);
        chk("txn_gnt_count", ng, 1);
    endtask

    function automatic logic any_out();
        return |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_done, bus.d_wready, bus.d_gnt,
                 bus.d_rvalid, bus.d_rdata, bus.d_done, bus.mem_addr, bus.mem_data_in,
                 bus.mem_access_size, bus.mem_rw, bus.mem_enable};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        int  g, d, gd, dd, w0, dc0, ig, k;
        bit  got;
        logic exp_d [4];

        bus.if_req = 0; bus.if_addr = '0; bus.if_size = '0;
        bus.d_req = 0; bus.d_rw = 0; bus.d_addr = '0; bus.d_size = '0;
        bus.mem_busy = 0;

        // Reset with both requests high: every output must stay low.
        bus.if_req = 1; bus.d_req = 1;
        #1;
        chk("reset_outputs", any_out(), 0);
        bus.if_req = 0; bus.d_req = 0;
        step; step;
        reset_n = 1;
        step;

        // IF single-word read.
        run_txn(0, 0, 32'h100, 2'd0, g, d);
        chk("t1_latency", d - g, 1 + RD_LAT);
        step;

        // D 4-word write at unaligned address.
        w0 = wready_cnt;
        run_txn(1, 1, 32'h203, 2'd1, g, d);
        chk("t2_done_cycle", d - g, 5);
        chk("t2_wready_pulses", wready_cnt - w0, 4);
        step;

        // Simultaneous requests: D 8-word read first, then IF.
        push_txn(1, 0, 32'h1000, 2'd2);
        push_txn(0, 0, 32'h300, 2'd0);
        set_req(1, 0, 32'h1000, 2'd2);
        set_req(0, 0, 32'h300, 2'd0);
        @(negedge clock);
        chk("t3_d_gnt", bus.d_gnt, 1);
        chk("t3_if_gnt_blocked", bus.if_gnt, 0);
        gd = cyc; dd = -1; ig = 0;
        for (int i = 0; i < 100 && dd < 0; i++) begin
            @(negedge clock);
            if (bus.if_gnt) ig++;
            if (bus.d_done) dd = cyc;
        end
        chk("t3_d_latency", dd - gd, 8 + RD_LAT);
        chk("t3_if_held_off", ig, 0);
        step;
        bus.d_req = 0;
        @(negedge clock);
        chk("t3_if_gnt_after_idle", bus.if_gnt, 1);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (bus.if_done) got = 1;
        end
        chk("t3_if_done_seen", got, 1);
        step;
        bus.if_req = 0;
        step;

        // IF 4-word read with 3 busy cycles on beat 2.
        push_txn(0, 0, 32'h400, 2'd1);
        set_req(0, 0, 32'h400, 2'd1);
        @(negedge clock);
        chk("t4_gnt", bus.if_gnt, 1);
        g = cyc;
        step; step; step;
        bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t4_busy_no_enable", bus.mem_enable, 0);
            chk("t4_busy_addr_held", bus.mem_addr, 32'h408);
            step;
        end
        bus.mem_busy = 0;
        d = -1;
        for (int i = 0; i < 50 && d < 0; i++) begin
            @(negedge clock);
            if (bus.if_done) d = cyc;
        end
        chk("t4_done_delayed", d - g, 4 + RD_LAT + 3);
        step;
        bus.if_req = 0;
        step;

        // Reset during beat 5 of a D 16-word read.
        push_txn(1, 0, 32'h800, 2'd3);
        set_req(1, 0, 32'h800, 2'd3);
        @(negedge clock);
        chk("t5_gnt", bus.d_gnt, 1);
        repeat (6) step;
        dc0 = d_done_cnt;
        reset_n = 0;
        #1;
        chk("t5_reset_outputs", any_out(), 0);
        beat_q.delete();
        rd_q.delete();
        bus.d_req = 0;
        step; step;
        chk("t5_no_done_in_reset", d_done_cnt - dc0, 0);
        reset_n = 1;
        step;
        run_txn(0, 0, 32'h40, 2'd0, g, d);
        chk("t5_after_reset_latency", d - g, 1 + RD_LAT);
        chk("t5_no_stale_done", d_done_cnt - dc0, 0);
        step;

        // Both requests held: grant order per tie-break policy.
`ifdef MEM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++)
            push_txn(exp_d[i], 0, exp_d[i] ? 32'h500 : 32'h600, 2'd0);
        set_req(1, 0, 32'h500, 2'd0);
        set_req(0, 0, 32'h600, 2'd0);
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            @(negedge clock);
            if (bus.if_gnt || bus.d_gnt) begin
                chk("t6_d_gnt", bus.d_gnt, exp_d[k]);
                chk("t6_if_gnt", bus.if_gnt, !exp_d[k]);
                k++;
            end
        end
        step;
        bus.d_req = 0; bus.if_req = 0;
        chk("t6_grant_count", k, 4);
        repeat (10) step;

        chk("beat_queue_drained", beat_q.size(), 0);
        chk("read_queue_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
